// File: rtl/adc_scan_avg.sv
// adc_scan_avg: scans N_CH ADC channels, averages 2^AVG_LOG2 samples per channel,
// converts each average to packed BCD with a bit-serial double-dabble engine, and
// flags channels whose ADC stops answering.
module adc_scan_avg #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned BCD_DIGITS = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  output logic                           cfg_req,
  output logic [$clog2(N_CH)-1:0]        cfg_chan,
  input  logic                           smp_valid,
  input  logic [DATA_W-1:0]              smp_data,
  output logic [N_CH*BCD_DIGITS*4-1:0]   bcd_out,
  output logic [N_CH-1:0]                ch_stale,
  output logic                           update,
  output logic [$clog2(N_CH)-1:0]        update_chan
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;
  localparam int unsigned BCD_W = BCD_DIGITS * 4;
  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACCUM,
    S_CONV,
    S_STORE
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   cur_chan;
  logic [CH_W-1:0]   next_chan;
  logic [DATA_W-1:0] smp_q;
  logic [ACC_W-1:0]  acc [N_CH];
  logic [CNT_W-1:0]  cnt [N_CH];
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TO_W-1:0]   to_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] bin_sh;
  logic [BCD_W-1:0]  bcd_sh;
  logic [BCD_W-1:0]  bcd_adj;

  // The requested/awaited channel is the current channel register itself.
  assign cfg_chan = cur_chan;

  // Channel advance with wrap, and the accumulator/count values after adding the held sample.
  always_comb begin
    next_chan = (cur_chan == CH_W'(N_CH - 1)) ? '0 : CH_W'(cur_chan + 1'b1);
    acc_sum   = acc[cur_chan] + ACC_W'(smp_q);
    cnt_inc   = CNT_W'(cnt[cur_chan] + 1'b1);
  end

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (bcd_sh[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_sh[d*4 +: 4] + 4'd3;
      end
    end
  end

  // Scan sequencer, per-channel averaging, BCD conversion and result slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur_chan    <= '0;
      cfg_req     <= 1'b0;
      smp_q       <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      bin_sh      <= '0;
      bcd_sh      <= '0;
      bcd_out     <= '0;
      ch_stale    <= '0;
      update      <= 1'b0;
      update_chan <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      cfg_req <= 1'b0;
      update  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            cfg_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A sample arriving in the expiry cycle takes priority over the timeout.
          if (smp_valid) begin
            smp_q <= smp_data;
            state <= S_ACCUM;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            ch_stale[cur_chan] <= 1'b1;
            acc[cur_chan]      <= '0;
            cnt[cur_chan]      <= '0;
            cur_chan           <= next_chan;
            state              <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (cnt_inc == CNT_W'(AVG_N)) begin
            bin_sh        <= DATA_W'(acc_sum >> AVG_LOG2);
            bcd_sh        <= '0;
            bit_cnt       <= '0;
            acc[cur_chan] <= '0;
            cnt[cur_chan] <= '0;
            state         <= S_CONV;
          end else begin
            acc[cur_chan] <= acc_sum;
            cnt[cur_chan] <= cnt_inc;
            cur_chan      <= next_chan;
            state         <= S_IDLE;
          end
        end
        S_CONV: begin
          {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
          bit_cnt          <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state <= S_STORE;
          end
        end
        S_STORE: begin
          for (int c = 0; c < int'(N_CH); c++) begin
            if (CH_W'(c) == cur_chan) begin
              bcd_out[c*BCD_W +: BCD_W] <= bcd_sh;
            end
          end
          ch_stale[cur_chan] <= 1'b0;
          update             <= 1'b1;
          update_chan        <= cur_chan;
          cur_chan           <= next_chan;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Self-checking bench for adc_scan_avg: a default instance driven by a randomized
// ADC responder with a per-channel averaging/BCD reference model, plus a
// 3-channel / 10-bit / no-averaging instance for the parameter sweep.
module tb_adc_scan_avg;

  localparam int TO = 1000;
  localparam int DW = 12;
  localparam int NA = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cfg_req;
  logic [1:0]  cfg_chan;
  logic        smp_valid;
  logic [11:0] smp_data;
  logic [63:0] bcd_out;
  logic [3:0]  ch_stale;
  logic        update;
  logic [1:0]  update_chan;

  logic        en1;
  logic        req1;
  logic [1:0]  chan1;
  logic        v1;
  logic [9:0]  d1;
  logic [47:0] bcd1;
  logic [2:0]  stale1;
  logic        upd1;
  logic [1:0]  uch1;

  adc_scan_avg dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_req(cfg_req), .cfg_chan(cfg_chan),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .bcd_out(bcd_out), .ch_stale(ch_stale),
    .update(update), .update_chan(update_chan)
  );

  adc_scan_avg #(.N_CH(3), .DATA_W(10), .AVG_LOG2(0), .BCD_DIGITS(4)) dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .cfg_req(req1), .cfg_chan(chan1),
    .smp_valid(v1), .smp_data(d1),
    .bcd_out(bcd1), .ch_stale(stale1),
    .update(upd1), .update_chan(uch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Reference model: running sum and count per channel, expected slots and stale flags.
  int          m_sum [4];
  int          m_cnt [4];
  int          m_next;
  logic [15:0] m_slot [4];
  logic [3:0]  m_stale;

  // Scenario knobs for the responder.
  int fixed_val   = -1;
  int fixed_delay = 0;
  int force_ch    = -1;
  int force_vals[$];
  int silent_ch   = -1;
  int late_ch     = -1;
  bit noise_on    = 1'b0;
  int stop_mode   = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_sum[c]  = 0;
      m_cnt[c]  = 0;
      m_slot[c] = '0;
    end
    m_stale = '0;
    m_next  = 0;
  endtask

  // Answers nreq channel requests and checks order, spacing, timeouts and results.
  task automatic test_traffic(input string tag, input int nreq);
    int ch, req_c, val_c, prev_c, exp_gap, d, smp, st_c, u_c;
    logic got;
    logic [1:0]  u_ch;
    logic [63:0] u_bcd;
    prev_c = -1;
    exp_gap = 0;
    for (int n = 0; n < nreq; n++) begin
      got = 1'b0;
      ch = -1;
      req_c = 0;
      for (int i = 0; i < TO + 50 && !got; i++) begin
        @(negedge clk);
        if (cfg_req) begin
          got = 1'b1;
          req_c = cyc;
          ch = int'(cfg_chan);
        end
      end
      total++;
      if (got !== 1'b1) begin
        $display("FAIL %s req_wait: no cfg_req within %0d cycles", tag, TO + 50);
        return;
      end
      passed++;
      total++;
      if (ch !== m_next) $display("FAIL %s cfg_chan: got %0d want %0d", tag, ch, m_next);
      else passed++;
      if (prev_c >= 0) begin
        total++;
        if (req_c - prev_c !== exp_gap)
          $display("FAIL %s req_spacing: got %0d want %0d", tag, req_c - prev_c, exp_gap);
        else passed++;
      end
      if (ch == silent_ch) begin
        silent_ch = -1;
        got = 1'b0;
        st_c = 0;
        for (int i = 0; i < TO + 20 && !got; i++) begin
          @(negedge clk);
          if (ch_stale[ch]) begin
            got = 1'b1;
            st_c = cyc;
          end
        end
        m_stale[ch] = 1'b1;
        m_sum[ch] = 0;
        m_cnt[ch] = 0;
        m_next = (ch + 1) % 4;
        total++;
        if (got !== 1'b1 || st_c - req_c !== TO + 1)
          $display("FAIL %s stale_time: seen=%0b after %0d want %0d", tag, got, st_c - req_c, TO + 1);
        else passed++;
        total++;
        if (ch_stale !== m_stale) $display("FAIL %s stale_flags: got %b want %b", tag, ch_stale, m_stale);
        else passed++;
        prev_c = req_c;
        exp_gap = TO + 2;
        continue;
      end
      if (ch == late_ch) begin
        d = TO;
        late_ch = -1;
      end else if (fixed_delay > 0) d = fixed_delay;
      else d = $urandom_range(6, 1);
      if (fixed_val >= 0) smp = fixed_val;
      else if (ch == force_ch && force_vals.size() > 0) smp = force_vals.pop_front();
      else smp = $urandom_range(4095, 0);
      repeat (d) @(negedge clk);
      smp_valid = 1'b1;
      smp_data = 12'(smp);
      val_c = cyc;
      @(negedge clk);
      smp_valid = 1'b0;
      smp_data = 12'($urandom);
      m_sum[ch] += smp;
      m_cnt[ch]++;
      m_next = (ch + 1) % 4;
      if (m_cnt[ch] < NA) begin
        prev_c = val_c;
        exp_gap = 3;
        continue;
      end
      m_slot[ch]  = to_bcd(m_sum[ch] / NA);
      m_stale[ch] = 1'b0;
      m_sum[ch]   = 0;
      m_cnt[ch]   = 0;
      if (stop_mode == 2) return;
      got = 1'b0;
      u_c = 0;
      u_ch = '0;
      u_bcd = '0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (noise_on && cyc == val_c + 4) begin
          smp_valid = 1'b1;
          smp_data = 12'($urandom);
        end else smp_valid = 1'b0;
        if (stop_mode == 1 && cyc == val_c + 6) enable = 1'b0;
        if (update) begin
          got = 1'b1;
          u_c = cyc;
          u_ch = update_chan;
          u_bcd = bcd_out;
        end
      end
      smp_valid = 1'b0;
      total++;
      if (got !== 1'b1 || u_c - val_c !== DW + 3)
        $display("FAIL %s update_time: seen=%0b after %0d want %0d", tag, got, u_c - val_c, DW + 3);
      else passed++;
      total++;
      if (int'(u_ch) !== ch) $display("FAIL %s update_chan: got %0d want %0d", tag, u_ch, ch);
      else passed++;
      total++;
      if (u_bcd !== {m_slot[3], m_slot[2], m_slot[1], m_slot[0]})
        $display("FAIL %s bcd_out: got %h want %h", tag, u_bcd,
                 {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
      else passed++;
      if (stop_mode == 1) return;
      prev_c = val_c;
      exp_gap = DW + 4;
    end
  endtask

  task automatic test_reset();
    int reqs;
    rst = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan} !== 74'd0)
      $display("FAIL reset_outputs: got %h want 0", {cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan});
    else passed++;
    rst = 1'b1;
    reqs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_req) reqs++;
    end
    total++;
    if (reqs !== 0) $display("FAIL reset_idle_req: got %0d requests want 0", reqs);
    else passed++;
    total++;
    if ({cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan} !== 74'd0)
      $display("FAIL reset_idle_outputs: got %h want 0", {cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan});
    else passed++;
  endtask

  task automatic test_full_scale();
    enable = 1'b1;
    fixed_val = 4095;
    fixed_delay = 2;
    test_traffic("full_scale", 16);
    fixed_val = -1;
    fixed_delay = 0;
    total++;
    if (bcd_out !== 64'h4095_4095_4095_4095)
      $display("FAIL full_scale_final: got %h want 4095409540954095", bcd_out);
    else passed++;
  endtask

  task automatic test_average();
    force_ch = 1;
    force_vals = '{100, 101, 102, 103, 0, 0, 0, 3};
    test_traffic("average", 16);
    total++;
    if (bcd_out[31:16] !== 16'h0101) $display("FAIL average_slot1: got %h want 0101", bcd_out[31:16]);
    else passed++;
    test_traffic("truncate", 16);
    total++;
    if (bcd_out[31:16] !== 16'h0000) $display("FAIL truncate_slot1: got %h want 0000", bcd_out[31:16]);
    else passed++;
    force_ch = -1;
  endtask

  task automatic test_timeout();
    silent_ch = 2;
    force_ch = 2;
    force_vals = '{250, 250, 250, 250};
    test_traffic("timeout", 20);
    force_ch = -1;
    total++;
    if (bcd_out[47:32] !== 16'h0250) $display("FAIL recover_slot2: got %h want 0250", bcd_out[47:32]);
    else passed++;
    total++;
    if (ch_stale !== 4'b0000) $display("FAIL recover_stale: got %b want 0000", ch_stale);
    else passed++;
  endtask

  task automatic test_expiry_race();
    late_ch = m_next;
    test_traffic("expiry_race", 4);
    total++;
    if (ch_stale !== 4'b0000) $display("FAIL expiry_race_stale: got %b want 0000", ch_stale);
    else passed++;
  endtask

  task automatic test_random_noise();
    noise_on = 1'b1;
    test_traffic("random_noise", 40);
    noise_on = 1'b0;
  endtask

  task automatic test_enable_drop();
    int reqs;
    stop_mode = 1;
    test_traffic("enable_drop", 100);
    stop_mode = 0;
    reqs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_req) reqs++;
    end
    total++;
    if (reqs !== 0) $display("FAIL enable_drop_park: got %0d requests want 0", reqs);
    else passed++;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_conv();
    int events;
    stop_mode = 2;
    test_traffic("reset_conv", 100);
    stop_mode = 0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan} !== 74'd0)
      $display("FAIL reset_conv_outputs: got %h want 0", {cfg_req, cfg_chan, bcd_out, ch_stale, update, update_chan});
    else passed++;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_clear();
    events = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (update || cfg_req || bcd_out !== 64'd0) events++;
    end
    total++;
    if (events !== 0) $display("FAIL reset_conv_quiet: got %0d events want 0", events);
    else passed++;
  endtask

  task automatic test_sweep();
    int ch, exp_ch, smp, d, vc, uc;
    logic got;
    logic [15:0] s1 [3];
    for (int c = 0; c < 3; c++) s1[c] = '0;
    exp_ch = 0;
    en1 = 1'b1;
    for (int n = 0; n < 9; n++) begin
      got = 1'b0;
      ch = -1;
      for (int i = 0; i < TO + 50 && !got; i++) begin
        @(negedge clk);
        if (req1) begin
          got = 1'b1;
          ch = int'(chan1);
        end
      end
      total++;
      if (got !== 1'b1) begin
        $display("FAIL sweep_req_wait: no cfg_req within %0d cycles", TO + 50);
        return;
      end
      passed++;
      total++;
      if (ch !== exp_ch) $display("FAIL sweep_chan: got %0d want %0d", ch, exp_ch);
      else passed++;
      smp = (n == 4) ? 1023 : int'($urandom_range(1023, 0));
      d = $urandom_range(4, 1);
      repeat (d) @(negedge clk);
      v1 = 1'b1;
      d1 = 10'(smp);
      vc = cyc;
      @(negedge clk);
      v1 = 1'b0;
      s1[ch] = to_bcd(smp);
      got = 1'b0;
      uc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        if (i > 0) @(negedge clk);
        if (upd1) begin
          got = 1'b1;
          uc = cyc;
        end
      end
      total++;
      if (got !== 1'b1 || uc - vc !== 13 || int'(uch1) !== ch)
        $display("FAIL sweep_update: seen=%0b after %0d chan %0d want 13 chan %0d", got, uc - vc, uch1, ch);
      else passed++;
      total++;
      if (bcd1 !== {s1[2], s1[1], s1[0]})
        $display("FAIL sweep_bcd: got %h want %h", bcd1, {s1[2], s1[1], s1[0]});
      else passed++;
      if (n == 4) begin
        total++;
        if (bcd1[ch*16 +: 16] !== 16'h1023) $display("FAIL sweep_full_scale: got %h want 1023", bcd1[ch*16 +: 16]);
        else passed++;
      end
      exp_ch = (ch + 1) % 3;
    end
    en1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    smp_valid = 1'b0;
    smp_data = '0;
    en1 = 1'b0;
    v1 = 1'b0;
    d1 = '0;
    model_clear();
    test_reset();
    test_full_scale();
    test_average();
    test_timeout();
    test_expiry_race();
    test_random_noise();
    test_enable_drop();
    test_reset_mid_conv();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_scan_avg.md
# adc_scan_avg

Parametrised successor to the four-channel external ADC front end. It sequences channel-select requests to an I2C ADC controller and accepts returned samples over a valid strobe. Per channel, it averages 2^AVG_LOG2 samples and converts each average to packed BCD with an iterative double-dabble engine. It sits between the ADC controller and the display multiplexer, and flags channels whose ADC stops answering.

## Interface
- N_CH, 4: number of scanned channels, ≥2; CH_W = clog2(N_CH).
- DATA_W, 12: raw sample width.
- AVG_LOG2, 2: log2 of samples averaged per update, 0..4.
- BCD_DIGITS, 4: digits per channel; must hold 2^DATA_W−1.
- TIMEOUT, 1000: WAIT cycles before a channel is declared stale, ≥2.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  scanning permitted.
- cfg_req  out  1  one-cycle request for a sample of cfg_chan.
- cfg_chan  out  CH_W  channel being requested or awaited.
- smp_valid  in  1  one-cycle strobe; smp_data holds a sample for cfg_chan.
- smp_data  in  DATA_W  raw sample.
- bcd_out  out  N_CH·BCD_DIGITS·4  packed BCD; channel c occupies bits [(c+1)·4·BCD_DIGITS−1 : c·4·BCD_DIGITS]; least-significant digit is lowest.
- ch_stale  out  N_CH  per-channel timeout flag.
- update  out  1  one-cycle pulse when a bcd_out slot is rewritten.
- update_chan  out  CH_W  slot written; valid while update is high.

## Operation
- Reset (rst=0): every output is 0, FSM is IDLE, cur_chan is 0, all accumulators and counters are 0.
- IDLE:
  - enable=1 → REQ.
  - enable is sampled only in IDLE. Deasserting it mid-channel lets the current channel finish, then the FSM parks in IDLE.
- REQ: cfg_req=1 for exactly one cycle, with cfg_chan=cur_chan → WAIT. The timeout counter clears.
- WAIT:
  - smp_valid=1: capture smp_data → ACCUM.
  - Otherwise, when the counter reaches TIMEOUT−1: set ch_stale[cur_chan], clear that channel's accumulator and sample count, advance the channel → IDLE.
  - smp_valid in the same cycle as expiry: the sample wins and no stale flag is set.
- ACCUM: acc[cur] += sample (width DATA_W+AVG_LOG2, cannot overflow) and cnt[cur]++.
  - If cnt reaches 2^AVG_LOG2: load avg = acc >> AVG_LOG2 (truncating), clear acc and cnt → CONV.
  - Else: advance the channel → IDLE.
- CONV: double-dabble over DATA_W cycles. Each cycle, add 3 to every digit ≥5, then shift left one bit, MSB first.
- STORE: write the BCD into slot cur, clear ch_stale[cur], pulse update with update_chan=cur, advance the channel → IDLE.
- Channel advance wraps from N_CH−1 to 0.
- smp_valid outside WAIT is ignored.
- Other slots of bcd_out hold their values. A stale channel keeps its last BCD value.

## Timing
- A non-final sample has smp_valid in cycle 0, ACCUM in cycle 1, IDLE in cycle 2, and the next cfg_req in cycle 3.
- For the final sample of a window, with smp_valid in cycle 0:
  - ACCUM is cycle 1.
  - CONV spans cycles 2..DATA_W+1.
  - STORE is cycle DATA_W+2.
  - update=1 and the new bcd_out appear in cycle DATA_W+3 (registered).
- On timeout, with cfg_req in cycle 0, ch_stale rises in cycle TIMEOUT+1.
- Asynchronous reset at any point, including mid-CONV, immediately returns all state to reset values. There is no partial slot write.

## Test plan
- Reset: hold rst=0, then release with enable=0 → all outputs 0, no cfg_req for 50 cycles.
- Full scale: defaults, answer every request with 4095 two cycles after cfg_req → after 4 windows, bcd_out = 0x4095_4095_4095_4095 and update_chan sequence 0,1,2,3, each update exactly 15 cycles after the 4th valid.
- Averaging: feed channel 1 with samples 100, 101, 102, 103 → slot 1 = 0x0101. Feed 0, 0, 0, 3 → 0x0000 (truncation).
- Timeout and recovery: never answer channel 2 → ch_stale=4'b0100 TIMEOUT+1 cycles after its cfg_req, next cfg_chan=3. Later answer 4 samples of 250 → ch_stale[2]=0, slot 2 = 0x0250.
- Boundary events: smp_valid in the expiry cycle → no stale flag. smp_valid during CONV → ignored. Drop enable during CONV → STORE completes, then no further cfg_req.
- Parameter sweep: N_CH=3, DATA_W=10, BCD_DIGITS=4, AVG_LOG2=0 → channel wraps 2→0, each valid yields an update 13 cycles later, and sample 1023 → 0x1023.
